keypad_bcd_entry: RTL and testbench
===================================

Name: keypad_bcd_entry

Overview:
- Clocked, parametrised successor to the combinational decimal-to-BCD keypad encoder.
- Synchronises and debounces raw key lines, then priority-checks them for a single key.
- Emits a one-cycle strobe per accepted keystroke.
- Shifts accepted digits into a multi-digit BCD entry register that feeds the cook-time/display path.
- Keeps the active-low enable and "any input" (AI) semantics of the original encoder.

Parameters:
NUM_KEYS, 10, number of decimal key lines (2..10); key line i encodes value i.
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (>=1).
NUM_DIGITS, 4, BCD digits held in the entry register (>=1).

Ports:
CLK  input  1  clock.
RST  input  1  synchronous, active-high reset.
EN  input  1  active-low enable; when 1, key lines are treated as all-zero.
DEC  input  NUM_KEYS  raw key lines, active-high, asynchronous to CLK.
CLR  input  1  synchronous clear of the entry register, COUNT and ERR.
BCD  output  4  code of the last accepted key (registered).
AI  output  1  debounced key-held indicator (registered).
KEY_VALID  output  1  one-cycle strobe on each accepted key.
ERR  output  1  sticky flag set when a stable multi-key pattern is debounced.
DIGITS  output  4*NUM_DIGITS  entry register; digit 0 in [3:0] is the most recent digit.
COUNT  output  $clog2(NUM_DIGITS+1)  number of digits entered; saturates at NUM_DIGITS.
FULL  output  1  high when COUNT==NUM_DIGITS.

Behaviour:
- Input path: DEC is registered once into s_dec. The effective pattern is p = EN ? 0 : s_dec.
- Reset (RST=1 at an edge):
  - s_dec=0; state=IDLE; debounce count=0.
  - Every output is 0.
  - RST overrides CLR and all key activity, including mid-debounce and mid-press.
- States IDLE, DEBOUNCE, PRESSED, RELEASE. Internal stable counter cnt; candidate register cand.
- IDLE:
  - p!=0: cand=p, cnt=1, go to DEBOUNCE.
  - Otherwise stay.
- DEBOUNCE:
  - p==0: go to IDLE.
  - p!=cand: cand=p, cnt=1.
  - p==cand and cnt<DEBOUNCE_CYCLES: cnt+1.
  - p==cand and cnt==DEBOUNCE_CYCLES: accept the candidate and go to PRESSED.
- Accept, when cand is one-hot:
  - KEY_VALID=1 for exactly one cycle; BCD=index of the set bit.
  - DIGITS shifts left by one digit with the new code into digit 0.
  - COUNT increments, saturating at NUM_DIGITS.
  - When FULL, the shift still happens and the oldest digit is discarded.
- Accept, when cand is not one-hot: ERR=1 (sticky). KEY_VALID stays 0; BCD, DIGITS and COUNT are unchanged.
- Latency: with DEC held stable from edge 1, KEY_VALID is high in the cycle after edge DEBOUNCE_CYCLES+2 (default: after edge 6).
- PRESSED:
  - AI=1.
  - Stays while p!=0. A changed or added key does not produce a new accept: no rollover, a full release is required.
  - p==0: cnt=1, go to RELEASE.
- RELEASE:
  - AI stays 1.
  - p!=0: go back to PRESSED (bounce on release).
  - p==0 and cnt<DEBOUNCE_CYCLES: cnt+1.
  - p==0 and cnt==DEBOUNCE_CYCLES: go to IDLE, AI=0.
- AI is 1 exactly in PRESSED and RELEASE, registered.
- EN deasserted (driven to 1) mid-operation:
  - p is forced to 0; DEBOUNCE aborts to IDLE.
  - PRESSED proceeds through the normal release path.
  - Entry register contents are retained.
- CLR:
  - DIGITS=0, COUNT=0, ERR=0 next cycle.
  - Does not affect BCD, the state machine or AI.
  - CLR in the same cycle as an accept: CLR wins for DIGITS, COUNT and ERR (the digit is dropped); KEY_VALID still pulses and BCD still updates.
- KEY_VALID never asserts on two consecutive cycles.
- At least 2*DEBOUNCE_CYCLES+2 cycles separate two strobes.

Test Plan:
- Default params; press DEC=10'b0000100000 for 10 cycles, then release -> KEY_VALID pulses once in the cycle after edge 6, BCD=5, AI=1 until 4 cycles after p==0, DIGITS=16'h0005, COUNT=1.
- Press key 3 bouncing 1,0,1,0 at a 1-cycle period, then stable for 10 cycles -> exactly one strobe, only after 4 stable cycles; no strobe during the bounce.
- Keys 1,2,3,4,5 entered with full releases -> DIGITS=16'h2345, COUNT=4, FULL=1; the 5th strobe still shifts and the oldest digit (1) is lost.
- DEC=10'b0000000110 stable -> ERR=1, no KEY_VALID, DIGITS unchanged; then CLR=1 for 1 cycle -> ERR=0, DIGITS=0, COUNT=0.
- Hold key 7, raise EN to 1 mid-debounce -> no strobe, AI stays 0. Repeat with EN raised while PRESSED -> AI falls 4 cycles later.
- Assert RST during PRESSED with DIGITS=16'h0012 -> all outputs 0 after the edge; a held key is re-debounced and re-accepted after reset.

Source files
------------

// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry
//   Clocked decimal keypad front end. Raw key lines are synchronised,
//   debounced and checked for a single key. Each accepted key gives a
//   one-cycle strobe and is shifted into a multi-digit BCD entry register.
//
// Ports
//   CLK        clock
//   RST        synchronous active-high reset
//   EN         active-low enable; when 1 the key lines read as all-zero
//   DEC        raw key lines, active-high, asynchronous to CLK
//   CLR        synchronous clear of DIGITS, COUNT and ERR
//   BCD        code of the last accepted key
//   AI         debounced key-held indicator
//   KEY_VALID  one-cycle strobe per accepted key
//   ERR        sticky flag: a stable multi-key pattern was debounced
//   DIGITS     entry register, digit 0 in [3:0] is the newest
//   COUNT      digits entered, saturating at NUM_DIGITS
//   FULL       COUNT == NUM_DIGITS
//
// state    | meaning
// IDLE     | no key seen
// DEBOUNCE | candidate pattern being qualified
// PRESSED  | key accepted and still held
// RELEASE  | all keys up, qualifying the release
module keypad_bcd_entry #(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              EN,
  input  logic [NUM_KEYS-1:0]               DEC,
  input  logic                              CLR,
  output logic [3:0]                        BCD,
  output logic                              AI,
  output logic                              KEY_VALID,
  output logic                              ERR,
  output logic [4*NUM_DIGITS-1:0]           DIGITS,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   COUNT,
  output logic                              FULL
);

  localparam int CW    = $clog2(NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_KEYS-1:0]     s_dec_q;
  logic [NUM_KEYS-1:0]     cand_q, cand_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    ai_q, ai_d;
  logic                    kv_q, kv_d;
  logic                    err_q, err_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [CW-1:0]           count_q, count_d;

  logic [NUM_KEYS-1:0]     p;
  logic                    accept;
  logic                    cand_onehot;
  logic [3:0]              cand_idx;

  assign p = EN ? '0 : s_dec_q;

  // Single-key check: exactly one bit set.
  assign cand_onehot = (cand_q != '0) && ((cand_q & (cand_q - 1'b1)) == '0);

  always_comb begin
    cand_idx = 4'd0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (cand_q[k]) cand_idx = 4'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    kv_d     = 1'b0;
    bcd_d    = bcd_q;
    err_d    = err_q;
    digits_d = digits_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (p != '0) begin
          cand_d  = p;
          cnt_d   = CNT_ONE;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (p == '0) begin
          state_d = IDLE;
        end else if (p != cand_q) begin
          cand_d = p;
          cnt_d  = CNT_ONE;
        end else if (cnt_q < DB_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          accept  = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        // No rollover: any nonzero pattern keeps us here until a full release.
        if (p == '0) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (p != '0) begin
          state_d = PRESSED;
        end else if (cnt_q < DB_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (cand_onehot) begin
        kv_d     = 1'b1;
        bcd_d    = cand_idx;
        digits_d = (digits_q << 4) | (4*NUM_DIGITS)'(cand_idx);
        if (count_q != CNT_FULL) count_d = count_q + CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    // Clear beats a same-cycle accept for the entry register and ERR only.
    if (CLR) begin
      digits_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end

    ai_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      s_dec_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ai_q     <= 1'b0;
      kv_q     <= 1'b0;
      err_q    <= 1'b0;
      digits_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_dec_q  <= DEC;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ai_q     <= ai_d;
      kv_q     <= kv_d;
      err_q    <= err_d;
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

  assign BCD       = bcd_q;
  assign AI        = ai_q;
  assign KEY_VALID = kv_q;
  assign ERR       = err_q;
  assign DIGITS    = digits_q;
  assign COUNT     = count_q;
  assign FULL      = (count_q == CNT_FULL);

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry: directed scenarios plus random key activity,
// compared cycle by cycle against a run-length reference model.
module tb_keypad_bcd_entry;

  localparam int NK = 10;
  localparam int DB = 4;
  localparam int ND = 4;
  localparam int CW = $clog2(ND + 1);

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic [NK-1:0] DEC;
  logic          CLR;
  logic [3:0]    BCD;
  logic          AI;
  logic          KEY_VALID;
  logic          ERR;
  logic [4*ND-1:0] DIGITS;
  logic [CW-1:0] COUNT;
  logic          FULL;

  keypad_bcd_entry #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .NUM_DIGITS(ND)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DEC(DEC), .CLR(CLR),
    .BCD(BCD), .AI(AI), .KEY_VALID(KEY_VALID), .ERR(ERR),
    .DIGITS(DIGITS), .COUNT(COUNT), .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a key is accepted when the effective pattern has been
  // the same nonzero value on DB+1 consecutive edges while no key is held;
  // the held condition ends after DB+1 consecutive all-zero edges.
  logic [NK-1:0] m_sdec;
  logic [NK-1:0] m_run_val;
  int            m_run_len;
  bit            m_held;
  bit            m_kv;
  bit            m_err;
  int            m_bcd;
  longint        m_digits;
  int            m_count;

  function automatic int key_index(input logic [NK-1:0] v);
    int idx = 0;
    for (int k = 0; k < NK; k++) if (v[k]) idx = k;
    return idx;
  endfunction

  task automatic model_edge();
    logic [NK-1:0] p;
    if (RST) begin
      m_sdec = '0; m_run_val = '0; m_run_len = 0; m_held = 0;
      m_kv = 0; m_err = 0; m_bcd = 0; m_digits = 0; m_count = 0;
    end else begin
      p      = EN ? '0 : m_sdec;
      m_sdec = DEC;
      if (p == m_run_val) m_run_len++;
      else begin
        m_run_val = p;
        m_run_len = 1;
      end
      m_kv = 0;
      if (!m_held) begin
        if (p != '0 && m_run_len >= DB + 1) begin
          m_held = 1;
          if ($countones(p) == 1) begin
            m_kv     = 1;
            m_bcd    = key_index(p);
            m_digits = ((m_digits * 16) + m_bcd) % (64'd1 << (4 * ND));
            if (m_count < ND) m_count++;
          end else begin
            m_err = 1;
          end
        end
      end else if (p == '0 && m_run_len >= DB + 1) begin
        m_held = 0;
      end
      if (CLR) begin
        m_digits = 0;
        m_count  = 0;
        m_err    = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("key_valid", 64'(KEY_VALID), 64'(m_kv));
    chk("ai",        64'(AI),        64'(m_held));
    chk("bcd",       64'(BCD),       64'(m_bcd));
    chk("err",       64'(ERR),       64'(m_err));
    chk("digits",    64'(DIGITS),    64'(m_digits));
    chk("count",     64'(COUNT),     64'(m_count));
    chk("full",      64'(FULL),      64'(m_count == ND));
  endtask

  task automatic step(input logic [NK-1:0] d, input logic e, input logic c, input logic r);
    DEC = d; EN = e; CLR = c; RST = r;
    @(posedge CLK);
    model_edge();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic hold(input logic [NK-1:0] d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_release(input int key);
    logic [NK-1:0] d;
    d = '0;
    d[key] = 1'b1;
    hold(d, 8);
    hold('0, 8);
  endtask

  logic [NK-1:0] k5, k3, k7, k9, k2, pat, d;
  int r, len;

  initial begin
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; DEC = '0;
    k5 = '0; k5[5] = 1'b1;
    k3 = '0; k3[3] = 1'b1;
    k7 = '0; k7[7] = 1'b1;
    k9 = '0; k9[9] = 1'b1;
    k2 = '0; k2[2] = 1'b1;

    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    chk("reset_digits", 64'(DIGITS), 64'd0);

    // Single key 5: strobe after edge 6.
    hold(k5, 5);
    chk("k5_no_early_kv", 64'(KEY_VALID), 64'd0);
    hold(k5, 1);
    chk("k5_kv", 64'(KEY_VALID), 64'd1);
    chk("k5_bcd", 64'(BCD), 64'd5);
    hold(k5, 1);
    chk("k5_kv_single", 64'(KEY_VALID), 64'd0);
    hold(k5, 3);
    hold('0, 5);
    chk("k5_ai_held", 64'(AI), 64'd1);
    hold('0, 1);
    chk("k5_ai_drop", 64'(AI), 64'd0);
    chk("k5_digits", 64'(DIGITS), 64'h0005);
    hold('0, 2);

    // CLR coincident with the accept edge: strobe survives, digit dropped.
    hold(k9, 5);
    step(k9, 1'b0, 1'b1, 1'b0);
    chk("clracc_kv", 64'(KEY_VALID), 64'd1);
    chk("clracc_bcd", 64'(BCD), 64'd9);
    chk("clracc_count", 64'(COUNT), 64'd0);
    hold(k9, 2);
    hold('0, 8);

    // Bouncing key 3.
    hold(k3, 1); hold('0, 1); hold(k3, 1); hold('0, 1);
    hold(k3, 10);
    hold('0, 8);

    // Keys 1..5: window keeps the four newest digits.
    for (int k = 1; k <= 5; k++) press_release(k);
    chk("seq_digits", 64'(DIGITS), 64'h2345);
    chk("seq_full", 64'(FULL), 64'd1);

    // Two-key pattern: ERR, entry unchanged, then CLR.
    hold(10'b0000000110, 12);
    chk("multi_err", 64'(ERR), 64'd1);
    chk("multi_digits", 64'(DIGITS), 64'h2345);
    hold('0, 8);
    step('0, 1'b0, 1'b1, 1'b0);
    chk("clr_err", 64'(ERR), 64'd0);
    hold('0, 2);

    // EN raised mid-debounce, then while pressed.
    hold(k7, 3);
    for (int i = 0; i < 8; i++) step(k7, 1'b1, 1'b0, 1'b0);
    hold('0, 3);
    hold(k7, 10);
    for (int i = 0; i < 8; i++) step(k7, 1'b1, 1'b0, 1'b0);
    hold('0, 8);

    // Reset while pressed with 0012 entered.
    step('0, 1'b0, 1'b1, 1'b0);
    press_release(1);
    hold(k2, 8);
    chk("pre_rst_digits", 64'(DIGITS), 64'h0012);
    step(k2, 1'b0, 1'b0, 1'b1);
    chk("rst_ai", 64'(AI), 64'd0);
    chk("rst_digits", 64'(DIGITS), 64'd0);
    hold(k2, 10);
    hold('0, 8);
    chk("rst_reaccept", 64'(DIGITS), 64'h0002);

    // Random activity.
    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 15);
      if (r < 9) begin
        pat = '0;
        pat[$urandom_range(0, NK - 1)] = 1'b1;
      end else if (r < 12) begin
        pat = '0;
      end else begin
        pat = NK'($urandom);
      end
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 9) == 0) ? '0 : pat;
        step(d, ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 299) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
